// File: rtl/odesa_pkg.sv
// Shared types and defaults for the ODESA layer trainer.
package odesa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_UPDATE,
    ST_DONE
  } state_t;

  localparam int DEF_NEURONS   = 4;
  localparam int DEF_INPUTS    = 2;
  localparam int DEF_WIDTH     = 9;
  localparam int DEF_ETA_SHIFT = 3;
  localparam int DEF_DELTA_T   = 'h00F;
  localparam int DEF_W         = 'h03F;
  localparam int DEF_THR       = 'h01FFF;
  localparam int DEF_WAIT_CLKS = 10;

  // Threshold width for a given weight/timestamp width.
  function automatic int tw_of(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/odesa_ema_update.sv
// One EMA lane: nxt = cur - (cur>>S) + (smp>>S), evaluated wide then truncated.
// With ODESA_TRAIN_SAT_EN defined the result clamps at all-ones instead of wrapping.
module odesa_ema_update
  import odesa_pkg::*;
#(
  parameter int P_DW    = 9,
  parameter int P_SW    = 9,
  parameter int P_EW    = 20,
  parameter int P_SHIFT = 3
) (
  input  logic [P_DW-1:0] cur,
  input  logic [P_SW-1:0] smp,
  output logic [P_DW-1:0] nxt
);

`ifdef ODESA_TRAIN_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [P_EW-1:0] cur_e, smp_e, sum;
  logic            ovf;

  assign cur_e = P_EW'(cur);
  assign smp_e = P_EW'(smp);
  assign sum   = cur_e - (cur_e >> P_SHIFT) + (smp_e >> P_SHIFT);
  assign ovf   = |sum[P_EW-1:P_DW];
  assign nxt   = (SAT_EN && ovf) ? '1 : sum[P_DW-1:0];

endmodule

// File: rtl/odesa_layer_trainer.sv
// Supervised per-layer trainer: collects winner/label over a window, then EMA-updates
// or decrements the labelled neuron. Optional saturation via ODESA_TRAIN_SAT_EN.
module odesa_layer_trainer
  import odesa_pkg::*;
#(
  parameter int P_NEURONS     = DEF_NEURONS,
  parameter int P_INPUTS      = DEF_INPUTS,
  parameter int P_WIDTH       = DEF_WIDTH,
  parameter int P_ETA_SHIFT   = DEF_ETA_SHIFT,
  parameter int P_DELTA_T     = DEF_DELTA_T,
  parameter int P_DEFAULT_W   = DEF_W,
  parameter int P_DEFAULT_THR = DEF_THR,
  parameter int P_WAIT_CLKS   = DEF_WAIT_CLKS
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [P_INPUTS-1:0]                       i_event,
  input  logic [P_NEURONS-1:0]                      i_spike,
  input  logic [P_NEURONS-1:0]                      i_label,
  input  logic [P_INPUTS*P_WIDTH-1:0]               i_ts,
  input  logic [P_NEURONS*tw_of(P_WIDTH)-1:0]       i_lv,
  input  logic                                      i_freeze,
  output logic                                      o_las,
  output logic                                      o_gas,
  output logic                                      o_busy,
  output logic                                      o_update,
  output logic [P_NEURONS*P_INPUTS*P_WIDTH-1:0]     o_weights,
  output logic [P_NEURONS*tw_of(P_WIDTH)-1:0]       o_thresholds
);

  localparam int N  = P_NEURONS;
  localparam int M  = P_INPUTS;
  localparam int W  = P_WIDTH;
  localparam int TW = tw_of(P_WIDTH);
  localparam int EW = TW + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(P_WAIT_CLKS + 1);

`ifdef ODESA_TRAIN_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t                        state, state_nxt;
  logic [CW-1:0]                 cnt;
  logic                          win_vld, lbl_vld;
  logic [IW-1:0]                 win_idx, lbl_idx;
  logic [M-1:0][W-1:0]           ts, ts_cap;
  logic [N-1:0][TW-1:0]          lv, thr_q, thr_ema, thr_dec;
  logic [N-1:0][M-1:0][W-1:0]    w_q, w_ema;
  logic                          start, take_win, take_lbl, do_write, hit;

  function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) idx = IW'(i);
    return idx;
  endfunction

  assign ts       = i_ts;
  assign lv       = i_lv;
  assign start    = (state == ST_IDLE) && (|i_event);
  assign take_win = start || ((state == ST_COLLECT) && !win_vld);
  assign take_lbl = start || ((state == ST_COLLECT) && !lbl_vld);
  assign do_write = (state == ST_UPDATE) && !i_freeze && lbl_vld;
  assign hit      = win_vld && (win_idx == lbl_idx);

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|i_event) state_nxt = ST_COLLECT;
      ST_COLLECT: if (cnt == CW'(P_WAIT_CLKS - 1)) state_nxt = ST_UPDATE;
      ST_UPDATE:  state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // First spike/label of the window wins; start re-arms both captures.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt     <= '0;
      win_vld <= 1'b0;
      win_idx <= '0;
      ts_cap  <= '0;
      lbl_vld <= 1'b0;
      lbl_idx <= '0;
    end else begin
      if (start)                    cnt <= '0;
      else if (state == ST_COLLECT) cnt <= cnt + 1'b1;
      if (take_win) begin
        win_vld <= |i_spike;
        win_idx <= lowest(i_spike);
        ts_cap  <= (|i_spike) ? ts : '0;
      end
      if (take_lbl) begin
        lbl_vld <= |i_label;
        lbl_idx <= lowest(i_label);
      end
    end

  for (genvar k = 0; k < N; k++) begin : g_nrn
    logic [EW-1:0] diff;
    assign diff       = EW'(thr_q[k]) - EW'(P_DELTA_T);
    assign thr_dec[k] = (SAT_EN && diff[TW]) ? '0 : diff[TW-1:0];

    odesa_ema_update #(.P_DW(TW), .P_SW(TW), .P_EW(EW), .P_SHIFT(P_ETA_SHIFT)) u_thr (
      .cur(thr_q[k]), .smp(lv[k]), .nxt(thr_ema[k])
    );
    for (genvar j = 0; j < M; j++) begin : g_in
      odesa_ema_update #(.P_DW(W), .P_SW(W), .P_EW(EW), .P_SHIFT(P_ETA_SHIFT)) u_w (
        .cur(w_q[k][j]), .smp(ts_cap[j]), .nxt(w_ema[k][j])
      );
    end
  end

  // Potentials are taken live during UPDATE; timestamps come from the capture.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int k = 0; k < N; k++) begin
        thr_q[k] <= TW'(P_DEFAULT_THR);
        for (int j = 0; j < M; j++) w_q[k][j] <= W'(P_DEFAULT_W);
      end
      o_update <= 1'b0;
    end else begin
      o_update <= do_write;
      if (do_write)
        for (int k = 0; k < N; k++)
          if (lbl_idx == IW'(k)) begin
            if (hit) begin
              thr_q[k] <= thr_ema[k];
              w_q[k]   <= w_ema[k];
            end else begin
              thr_q[k] <= thr_dec[k];
            end
          end
    end

  assign o_las        = |i_spike;
  assign o_gas        = |i_label;
  assign o_busy       = (state != ST_IDLE);
  assign o_weights    = w_q;
  assign o_thresholds = thr_q;

endmodule

// File: doc/odesa_layer_trainer.md
ODESA_LAYER_TRAINER -- requirements
Module: odesa_layer_trainer

Interface
REQ-001 The block SHALL have parameter P_NEURONS, default 4, giving the neuron count N.
REQ-002 The block SHALL have parameter P_INPUTS, default 2, giving the input channel count M.
REQ-003 The block SHALL have parameter P_WIDTH, default 9, giving the weight/timestamp width W; the threshold width SHALL be TW = 2*W+1.
REQ-004 The block SHALL have parameter P_ETA_SHIFT, default 3, giving the EMA learning-rate shift S.
REQ-005 The block SHALL have parameter P_DELTA_T, default 'h00F, giving the threshold decrement on a miss.
REQ-006 The block SHALL have parameters P_DEFAULT_W, default 'h03F, and P_DEFAULT_THR, default 'h01FFF, giving the reset values of weights and thresholds.
REQ-007 The block SHALL have parameter P_WAIT_CLKS, default 10, giving the collection window length in cycles.
REQ-008 Port i_clk: input, 1 bit, clock; all state SHALL be rising-edge, with no clocks derived from data.
REQ-009 Port i_rst_n: input, 1 bit, asynchronous active-low reset.
REQ-010 Port i_event: input, M bits, input-layer event strobes.
REQ-011 Port i_spike: input, N bits, this layer's output spikes.
REQ-012 Port i_label: input, N bits, one-hot supervisory label.
REQ-013 Port i_ts: input, M*W bits, per-input timestamps; channel j occupies bits [j*W +: W].
REQ-014 Port i_lv: input, N*TW bits, per-neuron potential at spike; neuron k occupies bits [k*TW +: TW].
REQ-015 Port i_freeze: input, 1 bit; when high it suppresses all learning (end of epochs).
REQ-016 Port o_las: output, 1 bit, equal to |i_spike (combinational).
REQ-017 Port o_gas: output, 1 bit, equal to |i_label (combinational).
REQ-018 Port o_busy: output, 1 bit, high while the FSM is not in IDLE.
REQ-019 Port o_update: output, 1 bit, one-cycle pulse coincident with newly written weights/thresholds.
REQ-020 Port o_weights: output, N*M*W bits; weight (k,j) occupies bits [(k*M+j)*W +: W].
REQ-021 Port o_thresholds: output, N*TW bits; neuron k occupies bits [k*TW +: TW].

Function
REQ-022 The FSM SHALL have states IDLE, COLLECT, UPDATE and DONE.
REQ-023 In IDLE, when |i_event is high, the FSM SHALL go to COLLECT, clear the window counter and clear the captures.
REQ-024 COLLECT SHALL last exactly P_WAIT_CLKS cycles, then go to UPDATE; i_event SHALL be ignored outside IDLE.
REQ-025 In IDLE-with-event and in COLLECT, the first cycle with |i_spike SHALL capture the winner (lowest set index) and all of i_ts; later spikes SHALL be ignored.
REQ-026 In IDLE-with-event and in COLLECT, the first cycle with |i_label SHALL capture the label (lowest set index); later labels SHALL be ignored.
REQ-027 UPDATE SHALL last one cycle; when i_freeze is low, register writes SHALL occur on the edge ending UPDATE and o_update SHALL pulse in the following cycle (DONE).
REQ-028 Hit (winner captured, label captured, winner == label k), for neuron k only: thr_k <= thr_k - (thr_k>>S) + (lv_k>>S), and for each j, w_kj <= w_kj - (w_kj>>S) + (ts_j>>S).
REQ-029 All EMA arithmetic SHALL be evaluated in TW+1 bits and truncated to the destination width.
REQ-030 Miss (label k captured, and no winner or winner != k): thr_k <= thr_k - P_DELTA_T; weights SHALL remain unchanged.
REQ-031 When no label is captured, no register SHALL change and o_update SHALL NOT pulse.
REQ-032 When i_freeze is high during UPDATE, no register SHALL change and o_update SHALL NOT pulse; the FSM SHALL sequence normally.
REQ-033 DONE SHALL last one cycle and then return to IDLE; an event during DONE SHALL be ignored.

Reset
REQ-034 Reset SHALL set all weights to P_DEFAULT_W, all thresholds to P_DEFAULT_THR, the FSM to IDLE, the counter and captures to 0, and o_busy and o_update to 0.
REQ-035 Reset asserted mid-COLLECT or mid-UPDATE SHALL abort the sequence with no partial write.

Configuration
REQ-036 With ODESA_TRAIN_SAT_EN defined, threshold decrement SHALL saturate at 0 and EMA results SHALL clamp at 2^TW-1 (weights at 2^W-1).
REQ-037 Without ODESA_TRAIN_SAT_EN, all results SHALL wrap modulo the destination width.

Structure
REQ-038 Package odesa_pkg SHALL hold the FSM state enum, the TW width function and the default constants.
REQ-039 A sub-module odesa_ema_update (parameterised width and shift, one EMA lane including the saturation option) SHALL be instantiated per weight and per threshold.

Verification
REQ-040 Reset -> every o_weights field = 'h03F, every o_thresholds field = 'h01FFF, o_busy=0.
REQ-041 event[0]; spike[2], label[2] in cycle 3; ts0='h080, ts1='h100, lv2='h04000 -> o_update 12 cycles after event; thr2='h02400, w20='h048, w21='h058, others unchanged.
REQ-042 label[3], spike[1] -> only thr3='h01FF0; weights and other thresholds unchanged.
REQ-043 label[1], no spike -> thr1='h01FF0; no weight change.
REQ-044 P_DEFAULT_THR=5, label[0], no spike -> thr0=0 with ODESA_TRAIN_SAT_EN, thr0='h7FFF6 without it.
REQ-045 Case A: i_freeze=1 with a hit -> no change and no o_update pulse. Case B: reset pulse in COLLECT cycle 5 -> defaults restored, FSM IDLE, next event processed normally.
